// File: rtl/exe_issue_ctrl_pkg.sv
// Shared types for the EXE issue controller: FSM state encoding, forwarding select codes,
// scoreboard entry layout and the default register index width.
package exe_issue_ctrl_pkg;

  localparam int unsigned RegIdxW = 5;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StStall = 2'd1,
    StBusy  = 2'd2,
    StFlush = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    FwdRf  = 2'd0,
    FwdExe = 2'd1,
    FwdMem = 2'd2
  } fwd_sel_e;

  typedef struct packed {
    logic               valid;
    logic [RegIdxW-1:0] rd;
    logic               is_load;
  } sb_entry_t;

  // Per-source result of the scoreboard lookup.
  typedef struct packed {
    logic     hazard;
    fwd_sel_e sel;
  } src_chk_t;

endpackage

// File: rtl/exe_hazard_sb.sv
// In-flight destination scoreboard plus per-source hazard / forwarding lookup.
// sb[0] is the instruction in EXE, older entries follow (MEM, WB, ...).
// Optional feature macro: EXE_FWD_EN (forwarding; only load-use in EXE stalls).
// Ports:
//   clk, rstl         clock, synchronous active-high reset
//   shift_en_i        advance the scoreboard (low while EXE is busy)
//   clr_head_i        force the new/held sb[0] entry invalid (redirect)
//   wr_valid_i        write a valid entry into sb[0] on this shift
//   wr_rd_i/load_i    destination and load flag of the entry written
//   rs1_*/rs2_*       source indices and read-enables of the decoded instruction
//   hz_rs*_o          source must stall
//   sel_rs*_o         forwarding select for the source
module exe_hazard_sb
  import exe_issue_ctrl_pkg::*;
#(
  parameter int unsigned INFLIGHT_DEPTH = 3
) (
  input  logic               clk,
  input  logic               rstl,
  input  logic               shift_en_i,
  input  logic               clr_head_i,
  input  logic               wr_valid_i,
  input  logic [RegIdxW-1:0] wr_rd_i,
  input  logic               wr_load_i,
  input  logic [RegIdxW-1:0] rs1_i,
  input  logic               rs1_used_i,
  input  logic [RegIdxW-1:0] rs2_i,
  input  logic               rs2_used_i,
  output logic               hz_rs1_o,
  output logic               hz_rs2_o,
  output fwd_sel_e           sel_rs1_o,
  output fwd_sel_e           sel_rs2_o
);

  sb_entry_t sb_q [INFLIGHT_DEPTH];
  sb_entry_t sb_d [INFLIGHT_DEPTH];
  src_chk_t  chk_rs1, chk_rs2;

  always_comb begin
    for (int i = 0; i < int'(INFLIGHT_DEPTH); i++) sb_d[i] = sb_q[i];
    if (shift_en_i) begin
      for (int i = int'(INFLIGHT_DEPTH) - 1; i > 0; i--) sb_d[i] = sb_q[i-1];
      sb_d[0] = '{valid: wr_valid_i, rd: wr_rd_i, is_load: wr_load_i};
    end
    // A redirect kills the slot behind the branch even while the pipe is frozen.
    if (clr_head_i) sb_d[0].valid = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rstl) begin
      sb_q <= '{default: '0};
    end else begin
      sb_q <= sb_d;
    end
  end

  function automatic src_chk_t check_src(logic [RegIdxW-1:0] src, logic used);
    src_chk_t r;
    r.hazard = 1'b0;
    r.sel    = FwdRf;
`ifdef EXE_FWD_EN
    // Walk oldest to youngest so the youngest match is the one that sticks.
    for (int i = int'(INFLIGHT_DEPTH) - 1; i >= 0; i--) begin
      if (used && (src != '0) && sb_q[i].valid && (sb_q[i].rd == src)) begin
        r.hazard = (i == 0) && sb_q[i].is_load;
        r.sel    = (i == 0) ? FwdExe : ((i == 1) ? FwdMem : FwdRf);
      end
    end
`else
    for (int i = 0; i < int'(INFLIGHT_DEPTH); i++) begin
      if (used && (src != '0) && sb_q[i].valid && (sb_q[i].rd == src)) r.hazard = 1'b1;
    end
`endif
    return r;
  endfunction

  always_comb begin
    chk_rs1 = check_src(rs1_i, rs1_used_i);
    chk_rs2 = check_src(rs2_i, rs2_used_i);
  end

  assign hz_rs1_o  = chk_rs1.hazard;
  assign hz_rs2_o  = chk_rs2.hazard;
  assign sel_rs1_o = chk_rs1.sel;
  assign sel_rs2_o = chk_rs2.sel;

`ifndef EXE_FWD_EN
  // Load flag only matters when forwarding is built in.
  logic [INFLIGHT_DEPTH-1:0] unused_is_load;
  for (genvar g = 0; g < INFLIGHT_DEPTH; g++) begin : g_unused
    assign unused_is_load[g] = sb_q[g].is_load;
  end
`endif

endmodule

// File: rtl/exe_issue_ctrl.sv
// Issue/hazard controller in front of the EXE stage: issues, stalls (RAW hazard / EXE busy)
// or kills (redirect) the decoded instruction each cycle.
// Optional feature macro: EXE_FWD_EN (forwarding selects driven, only load-use stalls).
// Ports:
//   clk, rstl                    clock, synchronous active-high reset
//   dec_valid_i / dec_ready_o    decode handshake
//   dec_rs*_i, dec_rs*_used_i    source indices and read-enables
//   dec_rd_i, dec_rd_wen_i       destination and write-enable
//   dec_is_load_i                instruction is a load
//   exe_busy_i                   EXE in a multi-cycle op
//   flush_from_exe               one-cycle redirect pulse
//   exe_issue_o                  registered issue strobe into EXE
//   fwd_rs*_sel_o                registered forwarding selects (0 RF, 1 EXE, 2 MEM)
//   state_o                      FSM state for debug
module exe_issue_ctrl
  import exe_issue_ctrl_pkg::*;
#(
  parameter int unsigned REG_IDX_W      = RegIdxW,
  parameter int unsigned INFLIGHT_DEPTH = 3,
  parameter int unsigned FLUSH_BUBBLES  = 2
) (
  input  logic                 clk,
  input  logic                 rstl,
  input  logic                 dec_valid_i,
  output logic                 dec_ready_o,
  input  logic [REG_IDX_W-1:0] dec_rs1_i,
  input  logic                 dec_rs1_used_i,
  input  logic [REG_IDX_W-1:0] dec_rs2_i,
  input  logic                 dec_rs2_used_i,
  input  logic [REG_IDX_W-1:0] dec_rd_i,
  input  logic                 dec_rd_wen_i,
  input  logic                 dec_is_load_i,
  input  logic                 exe_busy_i,
  input  logic                 flush_from_exe,
  output logic                 exe_issue_o,
  output logic [1:0]           fwd_rs1_sel_o,
  output logic [1:0]           fwd_rs2_sel_o,
  output logic [1:0]           state_o
);

  state_e     state_q;
  logic [1:0] flush_cnt_q;
  logic       issue_q;
  fwd_sel_e   sel_rs1_q, sel_rs2_q;

  logic       hz_rs1, hz_rs2, hazard, run_like, issue, wr_valid;
  fwd_sel_e   sel_rs1, sel_rs2;

  exe_hazard_sb #(
    .INFLIGHT_DEPTH(INFLIGHT_DEPTH)
  ) u_sb (
    .clk       (clk),
    .rstl      (rstl),
    .shift_en_i(!exe_busy_i),
    .clr_head_i(flush_from_exe),
    .wr_valid_i(wr_valid),
    .wr_rd_i   (RegIdxW'(dec_rd_i)),
    .wr_load_i (dec_is_load_i),
    .rs1_i     (RegIdxW'(dec_rs1_i)),
    .rs1_used_i(dec_rs1_used_i),
    .rs2_i     (RegIdxW'(dec_rs2_i)),
    .rs2_used_i(dec_rs2_used_i),
    .hz_rs1_o  (hz_rs1),
    .hz_rs2_o  (hz_rs2),
    .sel_rs1_o (sel_rs1),
    .sel_rs2_o (sel_rs2)
  );

  always_comb begin
    run_like = (state_q == StRun) || (state_q == StStall);
    hazard   = hz_rs1 || hz_rs2;
    issue    = run_like && dec_valid_i && !hazard && !exe_busy_i && !flush_from_exe;
    // x0 and non-writing instructions never occupy the scoreboard.
    wr_valid = issue && dec_rd_wen_i && (dec_rd_i != '0);
    // During a redirect decode is drained: accepted but killed.
    dec_ready_o = !rstl && (flush_from_exe || (state_q == StFlush) ||
                            (run_like && !exe_busy_i && !hazard));
  end

  always_ff @(posedge clk) begin
    if (rstl) begin
      state_q     <= StRun;
      flush_cnt_q <= '0;
      issue_q     <= 1'b0;
      sel_rs1_q   <= FwdRf;
      sel_rs2_q   <= FwdRf;
    end else begin
      issue_q   <= issue;
      sel_rs1_q <= issue ? sel_rs1 : FwdRf;
      sel_rs2_q <= issue ? sel_rs2 : FwdRf;
      if (flush_from_exe) begin
        state_q     <= StFlush;
        flush_cnt_q <= 2'(FLUSH_BUBBLES - 1);
      end else begin
        unique case (state_q)
          StFlush: begin
            if (flush_cnt_q == '0) state_q <= StRun;
            else                   flush_cnt_q <= flush_cnt_q - 2'd1;
          end
          StBusy: begin
            if (!exe_busy_i) state_q <= StRun;
          end
          StRun, StStall: begin
            if (exe_busy_i)                  state_q <= StBusy;
            else if (dec_valid_i && hazard)  state_q <= StStall;
            else                             state_q <= StRun;
          end
        endcase
      end
    end
  end

  assign exe_issue_o   = issue_q;
  assign fwd_rs1_sel_o = sel_rs1_q;
  assign fwd_rs2_sel_o = sel_rs2_q;
  assign state_o       = state_q;

endmodule
